xor_stream_cipher: RTL
======================

Name: xor_stream_cipher

Overview:
Parametrised streaming successor to the fixed 32-bit-key / 512-bit-message XOR cipher. The block loads a key of KEY_BITS in LANES-bit chunks. It then XORs an incoming message stream against the repeating key, one chunk per cycle, and emits ciphertext with start/end framing. No full-message buffering is done, so area is set by KEY_BITS, not message length. It sits between the pin-level input decode and the output pins of the cipher top.

Parameters:
KEY_BITS, 32, key length in bits; must be a multiple of LANES.
LANES, 1, bits per beat (1 = serial pin mode, 8 = byte mode).
MAX_MSG_BITS, 512, maximum message length in bits; must be a multiple of LANES.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
ena  input  1  global enable; 0 freezes all state.
data_in  input  LANES  key or message chunk.
load_key  input  1  level; key chunks are accepted while high.
load_msg  input  1  level; message chunks are accepted while high.
data_out  output  LANES  ciphertext chunk.
out_valid  output  1  data_out carries a ciphertext beat this cycle.
out_start  output  1  first beat of a message (coincides with out_valid).
out_end  output  1  single-cycle pulse, one cycle after the last valid beat.
key_ready  output  1  full key is loaded.
err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0, async): key register, counters, key index, data_out, out_valid, out_start, out_end, key_ready and err are all 0. Registered load_key_d and load_msg_d are also 0.
- ena=0: no register updates except that out_valid, out_start and out_end go to 0 on the next edge. data_out holds its value. A message in progress resumes when ena returns to 1.
- Key load (ena=1, load_key=1):
  - The first cycle with load_key=1 and load_key_d=0 starts a new key. On that cycle key_cnt and key_ready clear, err clears, and the cycle's chunk is shifted in.
  - Shift is MSB-first: key_reg <= {key_reg[KEY_BITS-LANES-1:0], data_in}. key_cnt += LANES.
  - When key_cnt reaches KEY_BITS, key_ready=1 on the following cycle. Further chunks are ignored and key_cnt saturates.
  - If load_key drops before KEY_BITS bits have arrived, key_ready stays 0.
- Message (ena=1, load_msg=1, load_key=0, key_ready=1):
  - The rising edge of load_msg (load_msg_d=0) starts a message: key_idx=0, msg_cnt=0.
  - Each accepted beat: data_out <= data_in ^ key chunk[key_idx], where chunk 0 is key_reg[KEY_BITS-1 -: LANES]. out_valid=1.
  - Latency is 1 cycle from the input beat to out_valid.
  - key_idx increments and wraps to 0 after KEY_BITS/LANES-1.
  - msg_cnt += LANES.
  - out_start=1 on the first output beat of each message only.
- Message termination:
  - Case A: load_msg falls. out_end pulses one cycle after the last valid beat. With continuous input, that is two cycles after the last input beat.
  - Case B: msg_cnt reaches MAX_MSG_BITS. The beat that reaches the limit is the last valid output, and out_end pulses on the next cycle. Remaining beats are dropped until load_msg falls, and err is set.
  - An empty message (load_msg high for zero accepted beats) produces no out_start and no out_end.
- Errors (err is sticky; cleared only by reset or by a new key-load start):
  - Message beat while key_ready=0: beat dropped, no output, err=1.
  - load_key and load_msg high together: key load wins, the message beat is dropped, err=1.
  - Message beats beyond MAX_MSG_BITS: dropped, err=1.
  - A new key load during a message ends the message immediately: out_end pulses next cycle, following Case A.
- Widths: key_cnt is $clog2(KEY_BITS+1) bits. msg_cnt is $clog2(MAX_MSG_BITS+1) bits. key_idx is $clog2(KEY_BITS/LANES) bits, minimum 1.
- Reset mid-operation clears everything. The next message requires a full key reload.

Test Plan:
- LANES=8, KEY_BITS=32. Load key bytes A5,A5,0F,0F, then message 3C. Required: key_ready=1; data_out=0x99 one cycle after the input; out_start=1 and out_valid=1 on that beat; out_end one cycle after it.
- Same key, message of five bytes 00. Required: outputs A5,A5,0F,0F,A5 (key wraps); out_start on beat 1 only; out_end once, after beat 5.
- LANES=1, KEY_BITS=4. Key bits 1,0,1,1, then message bits 1,1,1,1,1,1. Required: outputs 0,1,0,0,0,1.
- LANES=8, MAX_MSG_BITS=64. Send a 10-byte message. Required: exactly 8 valid beats, out_end on the cycle after beat 8, err=1, bytes 9–10 produce no out_valid.
- Send a message with no key loaded. Required: out_valid stays 0 and err=1. Then start a new key load. Required: err clears on that cycle.
- Drop ena for 3 cycles mid-message, then drop rst_n mid-message. Required:
  - During the ena stall: no out_valid and key_idx frozen; on resume, ciphertext continues with the correct key chunk.
  - On reset: all outputs go to 0 immediately (async), and key_ready stays 0 after reset.

Source files
------------

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: loads a KEY_BITS key in LANES-bit chunks, then XORs a
// framed message stream against the repeating key, one chunk per enabled cycle.
module xor_stream_cipher #(
  parameter int KEY_BITS     = 32,
  parameter int LANES        = 1,
  parameter int MAX_MSG_BITS = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [LANES-1:0] data_in,
  input  logic             load_key,
  input  logic             load_msg,
  output logic [LANES-1:0] data_out,
  output logic             out_valid,
  output logic             out_start,
  output logic             out_end,
  output logic             key_ready,
  output logic             err
);

  localparam int KEY_CHUNKS = KEY_BITS / LANES;
  localparam int KCW        = $clog2(KEY_BITS + 1);
  localparam int MCW        = $clog2(MAX_MSG_BITS + 1);
  localparam int IDW        = (KEY_CHUNKS > 1) ? $clog2(KEY_CHUNKS) : 1;

  localparam logic [KCW-1:0] KEY_FULL = KCW'(KEY_BITS);
  localparam logic [KCW-1:0] KEY_STEP = KCW'(LANES);
  localparam logic [MCW-1:0] MSG_FULL = MCW'(MAX_MSG_BITS);
  localparam logic [MCW-1:0] MSG_STEP = MCW'(LANES);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(KEY_CHUNKS - 1);

  logic [KEY_BITS-1:0] key_q, key_d;
  logic [KCW-1:0]      key_cnt_q, key_cnt_d;
  logic [IDW-1:0]      key_idx_q, key_idx_d;
  logic [MCW-1:0]      msg_cnt_q, msg_cnt_d;
  logic [LANES-1:0]    data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic                out_start_q, out_start_d;
  logic                out_end_q, out_end_d;
  logic                key_ready_q, key_ready_d;
  logic                err_q, err_d;
  logic                load_key_d_q, load_key_d_d;
  logic                load_msg_d_q, load_msg_d_d;
  logic                in_msg_q, in_msg_d;
  logic                hold_q, hold_d;

  logic [IDW-1:0]      idx_eff;
  logic [MCW-1:0]      cnt_eff;
  logic [LANES-1:0]    key_chunk;

  // Output contract: data_out is meaningful only while out_valid is high; there
  // is no backpressure, so every accepted input beat appears exactly one cycle later.
  always_comb begin
    key_d        = key_q;
    key_cnt_d    = key_cnt_q;
    key_idx_d    = key_idx_q;
    msg_cnt_d    = msg_cnt_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    out_start_d  = 1'b0;
    out_end_d    = 1'b0;
    key_ready_d  = key_ready_q;
    err_d        = err_q;
    load_key_d_d = load_key_d_q;
    load_msg_d_d = load_msg_d_q;
    in_msg_d     = in_msg_q;
    hold_d       = hold_q;
    idx_eff      = key_idx_q;
    cnt_eff      = msg_cnt_q;
    key_chunk    = '0;

    if (ena) begin
      load_key_d_d = load_key;
      load_msg_d_d = load_msg;

      if (load_key) begin
        if (!load_key_d_q) begin
          key_d     = (key_q << LANES) | KEY_BITS'(data_in);
          key_cnt_d = KEY_STEP;
          err_d     = 1'b0;
        end else if (key_cnt_q != KEY_FULL) begin
          key_d     = (key_q << LANES) | KEY_BITS'(data_in);
          key_cnt_d = key_cnt_q + KEY_STEP;
        end
        key_ready_d = (key_cnt_d == KEY_FULL);
      end

      // A rising load_msg restarts the key rotation and the length count.
      if (load_msg && !load_msg_d_q) begin
        idx_eff = '0;
        cnt_eff = '0;
      end

      for (int i = 0; i < KEY_CHUNKS; i++) begin
        if (idx_eff == IDW'(i)) key_chunk = key_q[KEY_BITS-1-i*LANES -: LANES];
      end

      if (load_msg) begin
        if (load_key || !key_ready_q || hold_q) begin
          err_d = 1'b1;
          // Once a key load interrupts, the stream stays closed until load_msg drops.
          if (load_key) hold_d = 1'b1;
        end else begin
          data_out_d  = data_in ^ key_chunk;
          out_valid_d = 1'b1;
          out_start_d = (cnt_eff == '0);
          key_idx_d   = (idx_eff == IDX_LAST) ? '0 : idx_eff + 1'b1;
          msg_cnt_d   = cnt_eff + MSG_STEP;
          in_msg_d    = 1'b1;
          if (msg_cnt_d == MSG_FULL) hold_d = 1'b1;
        end
      end else begin
        hold_d = 1'b0;
      end

      if (in_msg_q && (!load_msg || load_key || hold_q)) begin
        out_end_d = 1'b1;
        in_msg_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      key_cnt_q    <= '0;
      key_idx_q    <= '0;
      msg_cnt_q    <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      out_start_q  <= 1'b0;
      out_end_q    <= 1'b0;
      key_ready_q  <= 1'b0;
      err_q        <= 1'b0;
      load_key_d_q <= 1'b0;
      load_msg_d_q <= 1'b0;
      in_msg_q     <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      key_q        <= key_d;
      key_cnt_q    <= key_cnt_d;
      key_idx_q    <= key_idx_d;
      msg_cnt_q    <= msg_cnt_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      out_start_q  <= out_start_d;
      out_end_q    <= out_end_d;
      key_ready_q  <= key_ready_d;
      err_q        <= err_d;
      load_key_d_q <= load_key_d_d;
      load_msg_d_q <= load_msg_d_d;
      in_msg_q     <= in_msg_d;
      hold_q       <= hold_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_end   = out_end_q;
  assign key_ready = key_ready_q;
  assign err       = err_q;

endmodule
